// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared widths and FSM encoding for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

   localparam int DEF_INST_ADDR_WIDTH = 16;
   localparam int DEF_INST_WIDTH      = 16;
   localparam int DEF_QUEUE_DEPTH     = 2;

   // START holds the PC for one cycle after reset; DRAIN swallows a request
   // that was in flight when a redirect arrived.
   typedef enum logic [1:0] {
      IF_START = 2'd0,
      IF_FETCH = 2'd1,
      IF_DRAIN = 2'd2
   } if_state_e;

endpackage
`default_nettype wire

// File: rtl/if_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_queue
//  Description : Two-entry {pc, instruction} FIFO with flush; head registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_queue #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [AW-1:0] push_pc_i,
   input  logic [DW-1:0] push_inst_i,
   output logic [1:0]    count_o,
   output logic          head_valid_o,
   output logic [AW-1:0] head_pc_o,
   output logic [DW-1:0] head_inst_o
);

   logic [1:0]    count_q, count_d;
   logic [AW-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
   logic [DW-1:0] in0_q, in0_d, in1_q, in1_d;

   // Entry 0 is always the head; a pop shifts entry 1 forward.
   always_comb begin
      count_d = count_q;
      pc0_d   = pc0_q;
      in0_d   = in0_q;
      pc1_d   = pc1_q;
      in1_d   = in1_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else if (push_i && pop_i) begin
         if (count_q == 2'd2) begin
            pc0_d = pc1_q;
            in0_d = in1_q;
            pc1_d = push_pc_i;
            in1_d = push_inst_i;
         end else begin
            pc0_d = push_pc_i;
            in0_d = push_inst_i;
         end
      end else if (pop_i && count_q != 2'd0) begin
         pc0_d   = pc1_q;
         in0_d   = in1_q;
         count_d = count_q - 2'd1;
      end else if (push_i && count_q != 2'd2) begin
         if (count_q == 2'd0) begin
            pc0_d = push_pc_i;
            in0_d = push_inst_i;
         end else begin
            pc1_d = push_pc_i;
            in1_d = push_inst_i;
         end
         count_d = count_q + 2'd1;
      end
   end

   // Queue storage and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= 2'd0;
         pc0_q   <= '0;
         in0_q   <= '0;
         pc1_q   <= '0;
         in1_q   <= '0;
      end else begin
         count_q <= count_d;
         pc0_q   <= pc0_d;
         in0_q   <= in0_d;
         pc1_q   <= pc1_d;
         in1_q   <= in1_d;
      end
   end

   assign count_o      = count_q;
   assign head_valid_o = (count_q != 2'd0);
   assign head_pc_o    = pc0_q;
   assign head_inst_o  = in0_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Fetch FSM, pc_next mux and imem req/ack handshake feeding a
//                two-entry decode queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
   parameter int INST_WIDTH      = DEF_INST_WIDTH,
   parameter int QUEUE_DEPTH     = DEF_QUEUE_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [INST_ADDR_WIDTH-1:0] pc_cur,
   output logic [INST_ADDR_WIDTH-1:0] pc_next,
   output logic                       imem_req,
   output logic [INST_ADDR_WIDTH-1:0] imem_addr,
   input  logic                       imem_ack,
   input  logic [INST_WIDTH-1:0]      imem_data,
   input  logic                       redirect,
   input  logic [INST_ADDR_WIDTH-1:0] redirect_addr,
   output logic                       inst_valid,
   output logic [INST_WIDTH-1:0]      inst,
   output logic [INST_ADDR_WIDTH-1:0] inst_pc,
   input  logic                       inst_ready
);

   localparam logic [1:0]                 Q_FULL  = 2'(QUEUE_DEPTH);
   localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP = {{(INST_ADDR_WIDTH-1){1'b0}}, 1'b1};

   if_state_e                  state_q, state_d;
   logic [INST_ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;
   logic [1:0]                 q_count;
   logic                       push;
   logic                       pop;

   // A pop coinciding with a redirect is dropped: the queue is flushed anyway.
   assign pop = inst_valid && inst_ready && !redirect;

   // Next state, request generation and pc_next selection.
   always_comb begin
      state_d      = state_q;
      drain_addr_d = drain_addr_q;
      imem_req     = 1'b0;
      imem_addr    = pc_cur;
      pc_next      = pc_cur;
      push         = 1'b0;
      case (state_q)
         IF_START: begin
            state_d = IF_FETCH;
         end
         IF_FETCH: begin
            // A same-cycle pop frees a slot, so a full queue may still fetch.
            imem_req = (q_count < Q_FULL) || pop;
            if (imem_req && imem_ack) begin
               pc_next = pc_cur + PC_STEP;
               push    = !redirect;
            end
            if (redirect && imem_req && !imem_ack) begin
               state_d      = IF_DRAIN;
               drain_addr_d = pc_cur;
            end
         end
         IF_DRAIN: begin
            // Keep the abandoned request stable until memory acknowledges it.
            imem_req  = 1'b1;
            imem_addr = drain_addr_q;
            if (imem_ack) begin
               state_d = IF_FETCH;
            end
         end
         default: begin
            state_d = IF_START;
         end
      endcase
      if (redirect) begin
         pc_next = redirect_addr;
      end
   end

   // FSM state and drain address registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IF_START;
         drain_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   if_queue #(
      .AW (INST_ADDR_WIDTH),
      .DW (INST_WIDTH)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .pop_i        (pop),
      .flush_i      (redirect),
      .push_pc_i    (pc_cur),
      .push_inst_i  (imem_data),
      .count_o      (q_count),
      .head_valid_o (inst_valid),
      .head_pc_o    (inst_pc),
      .head_inst_o  (inst)
   );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Directed + random bench for if_fetch with pc register and
//                variable-latency memory models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pc_cur;
   logic [15:0] pc_next;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        redirect = 1'b0;
   logic [15:0] redirect_addr = 16'h0000;
   logic        inst_valid;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_ready = 1'b1;

   int vectors     = 0;
   int miscompares = 0;
   int lat         = 0;
   int mem_cnt;
   int pops        = 0;

   logic [15:0] exp_pc     = 16'h0000;
   logic        drain_pend = 1'b0;
   logic [15:0] drain_addr = 16'h0000;
   logic        hold_pend  = 1'b0;
   logic [15:0] hold_addr  = 16'h0000;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .pc_cur        (pc_cur),
      .pc_next       (pc_next),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .inst_ready    (inst_ready)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // pc register: no enable, resets to 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_cur <= 16'h0000;
      else      pc_cur <= pc_next;
   end

   // memory: acknowledges after 'lat' wait cycles of a held request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      mem_cnt <= 0;
      else if (!imem_req || imem_ack) mem_cnt <= 0;
      else                           mem_cnt <= mem_cnt + 1;
   end
   assign imem_ack  = imem_req && (mem_cnt >= lat);
   assign imem_data = mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      exp_pc     = 16'h0000;
      drain_pend = 1'b0;
      hold_pend  = 1'b0;
   endtask

   // one clock: protocol/pc_next checks, scoreboard, then advance to next negedge
   task automatic cycle();
      logic [15:0] nxt;
      #1;
      if (hold_pend) begin
         chk("req_held", imem_req, 1);
         chk("addr_held", imem_addr, hold_addr);
      end
      if (imem_req) chk("imem_addr", imem_addr, drain_pend ? drain_addr : pc_cur);
      nxt = pc_cur + 16'd1;
      if (redirect)                  chk("pc_next_redir", pc_next, redirect_addr);
      else if (imem_req && imem_ack) chk("pc_next_adv", pc_next, drain_pend ? pc_cur : nxt);
      else                           chk("pc_next_hold", pc_next, pc_cur);
      if (!redirect && inst_valid && inst_ready) begin
         chk("inst_pc", inst_pc, exp_pc);
         chk("inst", inst, mem_word(exp_pc));
         exp_pc = exp_pc + 16'd1;
         pops++;
      end
      hold_pend = imem_req && !imem_ack;
      hold_addr = imem_addr;
      if (imem_req && imem_ack) drain_pend = 1'b0;
      else if (redirect && imem_req) begin
         if (!drain_pend) drain_addr = pc_cur;
         drain_pend = 1'b1;
      end
      if (redirect) exp_pc = redirect_addr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      redirect = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid", inst_valid, 0);
      chk("rst_req", imem_req, 0);
      clear_model();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      #1;
      while (!inst_valid && n < budget) begin
         cycle();
         #1;
         n++;
      end
      chk("wait_valid", inst_valid, 1);
   endtask

   initial begin
      // ---- free-running, zero-wait, ready=1 ----
      lat = 0; inst_ready = 1'b1;
      do_reset();
      #1 chk("start_req", imem_req, 0);
      cycle();
      #1 chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 16'h0000);
      chk("first_empty", inst_valid, 0);
      cycle();
      for (int i = 0; i < 6; i++) begin
         #1 chk("stream_valid", inst_valid, 1);
         chk("stream_pc", inst_pc, i);
         cycle();
      end

      // ---- backpressure: queue fills at 2 entries ----
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) cycle();
      #1 chk("full_req", imem_req, 0);
      chk("full_pc", pc_cur, 16'h0002);
      chk("full_head", inst_pc, 16'h0000);
      inst_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("resume_valid", inst_valid, 1);
         chk("resume_pc", inst_pc, i);
         cycle();
      end

      // ---- 3-cycle latency, redirect during the wait ----
      lat = 3;
      do_reset();
      cycle();                       // START
      cycle();                       // 1st wait cycle
      redirect = 1'b1; redirect_addr = 16'h0040;
      cycle();                       // 2nd wait cycle
      redirect = 1'b0;
      #1 chk("drain_req", imem_req, 1);
      chk("drain_addr", imem_addr, 16'h0000);
      cycle();
      #1 chk("drain_ack", imem_ack, 1);
      chk("drain_addr2", imem_addr, 16'h0000);
      chk("drain_pc", pc_cur, 16'h0040);
      cycle();
      #1 chk("post_drain_addr", imem_addr, 16'h0040);
      wait_valid(20);
      chk("post_drain_head", inst_pc, 16'h0040);

      // ---- redirect coincident with ack of 0x0007 ----
      lat = 0;
      do_reset();
      begin
         int n;
         n = 0;
         #1;
         while (!(imem_req && imem_ack && pc_cur == 16'h0007) && n < 40) begin
            cycle();
            #1;
            n++;
         end
         chk("reach_pc7", pc_cur, 16'h0007);
      end
      redirect = 1'b1; redirect_addr = 16'h0100;
      cycle();
      redirect = 1'b0;
      #1 chk("flush_empty", inst_valid, 0);
      chk("refetch_addr", imem_addr, 16'h0100);
      wait_valid(10);
      chk("refetch_head", inst_pc, 16'h0100);

      // ---- wrap at 0xFFFF ----
      redirect = 1'b1; redirect_addr = 16'hFFFE;
      cycle();
      redirect = 1'b0;
      wait_valid(10);
      chk("wrap_a", inst_pc, 16'hFFFE);
      cycle();
      #1 chk("wrap_b", inst_pc, 16'hFFFF);
      cycle();
      #1 chk("wrap_c", inst_pc, 16'h0000);
      cycle();

      // ---- reset asserted mid-request with full queue ----
      lat = 2; inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 12; i++) cycle();
      #1 chk("pre_full", inst_valid, 1);
      chk("pre_idle", imem_req, 0);
      inst_ready = 1'b1;
      #1 chk("pre_req", imem_req, 1);
      #1 rst = 1'b0;
      #1 chk("mid_rst_valid", inst_valid, 0);
      chk("mid_rst_req", imem_req, 0);
      clear_model();
      lat = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("restart_start", imem_req, 0);
      cycle();
      #1 chk("restart_addr", imem_addr, 16'h0000);
      wait_valid(10);
      chk("restart_head", inst_pc, 16'h0000);

      // ---- randomized traffic ----
      pops = 0;
      for (int i = 0; i < 1000; i++) begin
         if (i % 50 == 0) lat = $urandom_range(0, 3);
         inst_ready = ($urandom_range(0, 3) != 0);
         redirect   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) redirect_addr = 16'hFFFC + 16'($urandom_range(0, 3));
         else                           redirect_addr = 16'($urandom);
         cycle();
      end
      redirect = 1'b0;
      chk("progress", (pops > 100), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
